// File: rtl/findmax_datapath.sv
// Scan datapath for an 8-entry buffer: init/step commands from an external controller find the
// largest unsigned value and its earliest index, reporting completion on scan_done.
module findmax_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init,
  input  logic              step,
  output logic              scan_done,
  output logic              busy,
  output logic [DATA_W-1:0] max_out,
  output logic [2:0]        max_idx
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [DATA_W-1:0] r_max_out;
  logic [2:0]        r_max_idx;
  logic [2:0]        r_idx;
  logic              w_step_ok;
  logic              w_gt;

  assign w_step_ok = step && (r_state == StScan);
  // Strict compare keeps the earliest index when values tie.
  assign w_gt      = r_buf[r_idx] > r_max_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (init) begin
      w_state_d = StScan;
    end else if (w_step_ok && (r_idx == 3'd7)) begin
      w_state_d = StDone;
    end
  end

  always_comb begin
    busy      = 1'b0;
    scan_done = 1'b0;
    unique case (r_state)
      StScan:  busy      = 1'b1;
      StDone:  scan_done = 1'b1;
      default: ;
    endcase
  end

  // Nonblocking update gives read-before-write against a same-cycle compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_out <= '0;
      r_max_idx <= '0;
      r_idx     <= '0;
    end else if (init) begin
      r_max_out <= r_buf[0];
      r_max_idx <= '0;
      r_idx     <= 3'd1;
    end else if (w_step_ok) begin
      if (w_gt) begin
        r_max_out <= r_buf[r_idx];
        r_max_idx <= r_idx;
      end
      if (r_idx != 3'd7) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign max_out = r_max_out;
  assign max_idx = r_max_idx;

endmodule
